pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the CHIP-8 core. Successor to the fixed 16-bit PC
//  register: adds an internal call/return stack (2NNN/00EE), skip (+4) and relative-jump modes.
//  Sits between decode (issues commands) and instruction memory (pc drives fetch address).
//  Single clock; all state updates on posedge clk.
// PARAMETERS
//  ADDR_W       12      PC and stack-entry width; all PC arithmetic is modulo 2**ADDR_W
//  START_ADDR   'h200   PC value after reset
//  STACK_DEPTH  16      return-stack entries, >=2
// PORTS
//  clk          in   1                  core clock
//  rst_n        in   1                  asynchronous, active-low reset
//  stall        in   1                  hold all state this cycle; overrides every command
//  advance      in   1                  normal step, pc += 2
//  skip         in   1                  conditional-skip taken, pc += 4
//  jump         in   1                  absolute jump, pc <= target
//  rel_jump     in   1                  offset jump (BNNN), pc <= target + offset
//  call         in   1                  push pc+2, pc <= target
//  ret          in   1                  pop, pc <= popped value
//  target       in   ADDR_W             jump/call/rel_jump address
//  offset       in   8                  unsigned offset for rel_jump (V0), zero-extended
//  pc           out  ADDR_W             current fetch address
//  depth        out  $clog2(STACK_DEPTH+1)  entries currently on the stack
//  stack_full   out  1                  depth == STACK_DEPTH
//  stack_empty  out  1                  depth == 0
//  fault        out  1                  stack fault flag (tied 0 unless PC_STACK_FAULT_EN)
// BEHAVIOUR
//  - Reset (rst_n low, async): pc=START_ADDR, depth=0, fault=0, stack_empty=1, stack_full=0.
//    Stack contents are not reset. Release takes effect at the first posedge after deassertion.
//  - Latency: a command sampled at posedge N is visible on pc/depth after posedge N (1 cycle).
//    No internal pipeline; a new command may be issued every cycle.
//  - Priority if more than one command is high: stall > jump > rel_jump > call > ret > skip > advance.
//    No command and no stall: hold (waiting on keypress, FX0A).
//  - Arithmetic: pc+2, pc+4 and target+offset are truncated to ADDR_W (0xFFE+2 -> 0x000 at ADDR_W=12).
//    Odd addresses are legal and are not corrected.
//  - call: stack[depth] <= pc+2 (truncated); depth++; pc <= target, all in the same edge.
//  - ret: pc <= stack[depth-1]; depth--. Stack is register-based, so no read latency.
//  - stack_full and stack_empty are combinational decodes of depth.
//  - Boundaries without PC_STACK_FAULT_EN:
//      call while full  -> act as jump: pc <= target, no push, depth unchanged.
//      ret while empty  -> no-op: pc and depth held.
//  - call and ret together: call wins, and ret is dropped (no simultaneous push/pop).
//  - Async reset asserted mid-sequence overrides everything immediately; no command completes.
// CONFIGURATION
//  PC_STACK_FAULT_EN defined:
//   - call while full, or ret while empty, sets fault=1 and leaves pc, depth and stack unchanged.
//   - fault is sticky. While fault=1, all commands are ignored and pc is frozen.
//     Only rst_n clears it.
//  PC_STACK_FAULT_EN undefined: fault output tied to 0; boundary handling as in BEHAVIOUR.
// TESTING
//  1 Reset + advance x3 -> pc 0x200,0x202,0x204,0x206; depth=0; stack_empty=1.
//  2 At pc=0x200: skip -> 0x204; jump target=0x3FE -> 0x3FE; rel_jump target=0x300, offset=0x10 -> 0x310.
//  3 At pc=0x204: call 0x400 -> pc=0x400, depth=1; call 0x500 -> pc=0x500, depth=2;
//    ret -> pc=0x402; ret -> pc=0x206, depth=0.
//  4 Wrap and priority: pc=0xFFE, advance -> 0x000; stall+jump 0x123 -> pc held;
//    jump+call 0x456 (same target) -> pc=0x456, depth unchanged.
//  5 Overflow and underflow: 16 calls -> stack_full=1; 17th call 0x700.
//    Without macro: pc=0x700, depth=16. With macro: fault=1, pc held; later advance ignored.
//    From empty, ret: pc held (without macro) or fault=1 (with macro).
//  6 Reset mid-run: depth=3, pc=0x5A0, assert rst_n asynchronously between edges
//    -> pc=0x200, depth=0, fault=0 before the next edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Command/status bus between CHIP-8 decode (master) and the program-counter unit (slave).
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned STACK_DEPTH = 16
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               stall;
    logic               advance;
    logic               skip;
    logic               jump;
    logic               rel_jump;
    logic               call;
    logic               ret;
    logic [ADDR_W-1:0]  target;
    logic [7:0]         offset;
    logic [ADDR_W-1:0]  pc;
    logic [DEPTH_W-1:0] depth;
    logic               stack_full;
    logic               stack_empty;
    logic               fault;

    modport master (
        output stall, advance, skip, jump, rel_jump, call, ret, target, offset,
        input  pc, depth, stack_full, stack_empty, fault
    );

    modport slave (
        input  stall, advance, skip, jump, rel_jump, call, ret, target, offset,
        output pc, depth, stack_full, stack_empty, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// CHIP-8 program counter with register-based call/return stack, skip and relative jump.
// Optional PC_STACK_FAULT_EN: stack overflow/underflow raises a sticky fault that freezes the unit.
module pc_sequencer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned START_ADDR  = 'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [PTR_W-1:0]   push_ptr, pop_ptr;
    logic [ADDR_W-1:0]  push_data;
    logic               push_en;
    logic               full, empty;
    logic               fault_q;
`ifdef PC_STACK_FAULT_EN
    logic               fault_d;
`endif

    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign push_ptr = PTR_W'(depth_q);
    assign pop_ptr  = PTR_W'(depth_q - DEPTH_W'(1));

    // Next-state: stall > jump > rel_jump > call > ret > skip > advance; otherwise hold.
    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        push_en   = 1'b0;
        push_data = pc_q + ADDR_W'(2);
`ifdef PC_STACK_FAULT_EN
        fault_d   = fault_q;
`endif
        if (!bus.stall && !fault_q) begin
            if (bus.jump) begin
                pc_d = bus.target;
            end else if (bus.rel_jump) begin
                pc_d = bus.target + ADDR_W'(bus.offset);
            end else if (bus.call) begin
                if (!full) begin
                    push_en = 1'b1;
                    depth_d = depth_q + DEPTH_W'(1);
                    pc_d    = bus.target;
                end else begin
`ifdef PC_STACK_FAULT_EN
                    fault_d = 1'b1;
`else
                    pc_d    = bus.target;
`endif
                end
            end else if (bus.ret) begin
                if (!empty) begin
                    pc_d    = stack_q[pop_ptr];
                    depth_d = depth_q - DEPTH_W'(1);
                end
`ifdef PC_STACK_FAULT_EN
                else begin
                    fault_d = 1'b1;
                end
`endif
            end else if (bus.skip) begin
                pc_d = pc_q + ADDR_W'(4);
            end else if (bus.advance) begin
                pc_d = pc_q + ADDR_W'(2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= ADDR_W'(START_ADDR);
            depth_q <= '0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

`ifdef PC_STACK_FAULT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
`else
    assign fault_q = 1'b0;
`endif

    // Return-address storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_ptr] <= push_data;
    end

    assign bus.pc          = pc_q;
    assign bus.depth       = depth_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.fault       = fault_q;
endmodule
